uprj_slot_ctrl: RTL and testbench
=================================

# uprj_slot_ctrl

Sequencer that shares the fabric's top user-IO return bus between several hardened user-project slots. It accepts slot-switch requests from the fabric and quiesces the outgoing slot by holding it in reset with the bus gated. It then switches a registered bus multiplexer, holds the incoming slot in reset for a fixed window, and releases it. It sits between the fabric's UIO_TOP outputs (request/select side) and UIO_TOP_UIN (return bus), replacing the raw select-indexed mux.

## Interface
Parameters:
- NUM_SLOTS, 4, number of user-project slots (2..16)
- SEL_W, 2, slot-index width; 2**SEL_W >= NUM_SLOTS
- BUS_W, 128, width of each slot's return bus
- QUIET_CYCLES, 4, cycles the bus is gated and the old slot held in reset before the switch (>=1)
- RST_CYCLES, 16, cycles the new slot is held in reset after the switch (>=1)

Ports:
- CLK  in  1  fabric clock; all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  switch request
- req_slot  in  SEL_W  requested slot index
- req_ready  out  1  controller can accept a request
- active_slot  out  SEL_W  slot currently routed to the bus
- slot_rst  out  NUM_SLOTS  per-slot active-high reset
- switching  out  1  high while a switch sequence is in progress
- done_pulse  out  1  one-cycle pulse when a sequence completes
- err_bad_slot  out  1  sticky flag: out-of-range request seen
- slot_in  in  NUM_SLOTS*BUS_W  concatenated slot return buses; slot k at [k*BUS_W +: BUS_W]
- bus_out  out  BUS_W  registered, gated return bus to fabric

## Operation
- FSM states: IDLE, QUIESCE, SWITCH, HOLD.
- Reset values: state=HOLD, counter=RST_CYCLES-1, active_slot=0, slot_rst=all ones, switching=1, req_ready=0, done_pulse=0, err_bad_slot=0, bus_out=0, bus_en=0. After resetn rises, slot 0 therefore goes through a normal HOLD window before first use.
- IDLE:
  - req_ready=1, bus_en=1, switching=0.
  - slot_rst has only active_slot bit clear. Non-active slots are always held in reset.
- Accept:
  - A request is accepted when req_valid & req_ready. The target is latched from req_slot.
  - If req_slot >= NUM_SLOTS, the request is consumed, the state stays IDLE, err_bad_slot sets (cleared only by resetn), and there is no done_pulse.
  - Otherwise the FSM goes to QUIESCE with counter=QUIET_CYCLES-1.
  - A request for the current active_slot runs the full sequence and acts as a soft reset of that slot.
- QUIESCE:
  - bus_en=0 and slot_rst is all ones.
  - Counter decrements each cycle; at 0 the FSM goes to SWITCH.
- SWITCH (one cycle): active_slot<=target, counter<=RST_CYCLES-1, then HOLD.
- HOLD:
  - slot_rst is all ones and bus_en=0.
  - Counter decrements; at 0 the FSM goes to IDLE with done_pulse=1 for that IDLE cycle.
- req_valid outside IDLE is ignored (req_ready=0). The requester must hold the request until it is accepted.
- Bus gating: bus_out <= bus_en ? slot_in[active_slot] : 0. bus_en and active_slot are the current-cycle decoded values.
- Asynchronous reset mid-sequence aborts the sequence immediately and returns to the reset values above.

## Timing
- Accepting edge T: from T+1, req_ready=0, switching=1, slot_rst=all ones, bus_en=0. bus_out is zero from T+2.
- QUIESCE occupies T+1..T+QUIET_CYCLES.
- SWITCH is at T+QUIET_CYCLES+1; active_slot shows the new value from T+QUIET_CYCLES+2.
- HOLD occupies RST_CYCLES cycles.
- IDLE is re-entered at T+QUIET_CYCLES+RST_CYCLES+2, with req_ready=1, done_pulse=1 and new-slot reset released in that cycle. The first valid bus_out data appears one cycle later.
- A back-to-back request is accepted on the first IDLE edge, so done_pulse and accept can coincide.
- Bus latency in IDLE: 1 cycle from slot_in to bus_out.
- Post-reset: IDLE is reached RST_CYCLES cycles after the first edge with resetn high.

## Structure
- Package uprj_slot_pkg holds:
  - the state enum (IDLE/QUIESCE/SWITCH/HOLD);
  - the localparam counter width $clog2(max(QUIET_CYCLES,RST_CYCLES)+1);
  - default parameter constants.
- Sub-module uprj_bus_mux: registered, gated NUM_SLOTS:1 mux (slot_in, sel, en -> bus_out). The async reset clears bus_out.
- The top holds the FSM, counter, target latch and error flag.

## Test plan
- Reset release, no requests: slot_rst=4'b1111 for 16 cycles, then 4'b1110. req_ready rises with a done_pulse, and bus_out equals slot_in[0] one cycle later.
- Request slot 2 at edge T (defaults): bus_out=0 from T+2. active_slot=2 from T+6. slot_rst=4'b1011 and req_ready=1 at T+22, and bus_out=slot_in[2] at T+23.
- NUM_SLOTS=3, request slot 3: err_bad_slot=1 next cycle, active_slot unchanged, no switching and no done_pulse. A later valid request still works and the flag stays set.
- Request the current slot 1: full sequence with slot_rst[1] high for 4+1+16 cycles, then active_slot=1.
- Hold req_valid during a sequence with a different slot: it is ignored until IDLE, then accepted on the done_pulse cycle. The sequence restarts with the new target.
- Assert resetn low during HOLD: all outputs go to reset values immediately. After release, the slot-0 reset window repeats.

Source files
------------

// File: rtl/uprj_slot_pkg.sv
// Shared types and defaults for the user-project slot sequencer.
// Holds the FSM state encoding and the counter-width helper.
package uprj_slot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        SWITCH  = 2'd2,
        HOLD    = 2'd3
    } slot_state_t;

    localparam int DEF_NUM_SLOTS    = 4;
    localparam int DEF_SEL_W        = 2;
    localparam int DEF_BUS_W        = 128;
    localparam int DEF_QUIET_CYCLES = 4;
    localparam int DEF_RST_CYCLES   = 16;

    // One counter serves both the quiesce and the hold window, so size it for the longer one.
    function automatic int cnt_width(input int quiet_cycles, input int rst_cycles);
        int longest;
        longest = (quiet_cycles > rst_cycles) ? quiet_cycles : rst_cycles;
        return $clog2(longest + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_QUIET_CYCLES, DEF_RST_CYCLES);

endpackage

// File: rtl/uprj_slot_ctrl_if.sv
// Request/select and return-bus signals between the fabric (master) and the slot controller (slave).
interface uprj_slot_ctrl_if #(
    parameter int NUM_SLOTS = uprj_slot_pkg::DEF_NUM_SLOTS,
    parameter int SEL_W     = uprj_slot_pkg::DEF_SEL_W,
    parameter int BUS_W     = uprj_slot_pkg::DEF_BUS_W
);
    logic                       req_valid;
    logic [SEL_W-1:0]           req_slot;
    logic                       req_ready;
    logic [SEL_W-1:0]           active_slot;
    logic [NUM_SLOTS-1:0]       slot_rst;
    logic                       switching;
    logic                       done_pulse;
    logic                       err_bad_slot;
    logic [NUM_SLOTS*BUS_W-1:0] slot_in;
    logic [BUS_W-1:0]           bus_out;

    modport master (
        output req_valid, req_slot, slot_in,
        input  req_ready, active_slot, slot_rst, switching, done_pulse, err_bad_slot, bus_out
    );

    modport slave (
        input  req_valid, req_slot, slot_in,
        output req_ready, active_slot, slot_rst, switching, done_pulse, err_bad_slot, bus_out
    );

endinterface

// File: rtl/uprj_bus_mux.sv
// Registered, gated NUM_SLOTS:1 return-bus multiplexer.
// Unused select codes map to an all-zero way so the index is always in range.
module uprj_bus_mux import uprj_slot_pkg::*; #(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int BUS_W     = DEF_BUS_W
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [NUM_SLOTS*BUS_W-1:0] slot_in,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       en,
    output logic [BUS_W-1:0]           bus_out
);
    localparam int NUM_WAYS = 1 << SEL_W;

    logic [BUS_W-1:0] way_data [NUM_WAYS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            if (gi < NUM_SLOTS) begin : g_slot
                assign way_data[gi] = slot_in[gi*BUS_W +: BUS_W];
            end else begin : g_pad
                assign way_data[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            bus_out <= '0;
        end else if (en) begin
            bus_out <= way_data[sel];
        end else begin
            bus_out <= '0;
        end
    end

endmodule

// File: rtl/uprj_slot_ctrl.sv
// Slot-switch sequencer: quiesce old slot, switch the return-bus mux, hold new slot in reset, release.
// All control outputs are registered straight out of the FSM.
module uprj_slot_ctrl import uprj_slot_pkg::*; #(
    parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
    parameter int SEL_W        = DEF_SEL_W,
    parameter int BUS_W        = DEF_BUS_W,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic            CLK,
    input  logic            resetn,
    uprj_slot_ctrl_if.slave sif
);
    localparam int              CW         = cnt_width(QUIET_CYCLES, RST_CYCLES);
    localparam logic [CW-1:0]   QUIET_LOAD = CW'(QUIET_CYCLES - 1);
    localparam logic [CW-1:0]   RST_LOAD   = CW'(RST_CYCLES - 1);

    slot_state_t          state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [SEL_W-1:0]     target_reg;
    logic [SEL_W-1:0]     active_reg;
    logic [NUM_SLOTS-1:0] slot_rst_reg;
    logic                 ready_reg;
    logic                 switching_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic                 bus_en_reg;
    logic                 accept;
    logic                 req_bad;

    // Every slot in reset except the one currently routed to the bus.
    function automatic logic [NUM_SLOTS-1:0] run_mask(input logic [SEL_W-1:0] slot);
        logic [NUM_SLOTS-1:0] mask;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            mask[k] = (32'(slot) != k);
        end
        return mask;
    endfunction

    assign accept  = sif.req_valid & ready_reg;
    assign req_bad = (32'(sif.req_slot) >= NUM_SLOTS);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= HOLD;
            cnt_reg       <= RST_LOAD;
            target_reg    <= '0;
            active_reg    <= '0;
            slot_rst_reg  <= '1;
            ready_reg     <= 1'b0;
            switching_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            bus_en_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Out-of-range requests are swallowed; only the sticky flag records them.
                        if (req_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            target_reg    <= sif.req_slot;
                            cnt_reg       <= QUIET_LOAD;
                            state_reg     <= QUIESCE;
                            ready_reg     <= 1'b0;
                            switching_reg <= 1'b1;
                            slot_rst_reg  <= '1;
                            bus_en_reg    <= 1'b0;
                        end
                    end
                end
                QUIESCE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SWITCH;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                SWITCH: begin
                    active_reg <= target_reg;
                    cnt_reg    <= RST_LOAD;
                    state_reg  <= HOLD;
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= IDLE;
                        ready_reg     <= 1'b1;
                        switching_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        bus_en_reg    <= 1'b1;
                        slot_rst_reg  <= run_mask(active_reg);
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= HOLD;
                    cnt_reg   <= RST_LOAD;
                end
            endcase
        end
    end

    assign sif.req_ready    = ready_reg;
    assign sif.active_slot  = active_reg;
    assign sif.slot_rst     = slot_rst_reg;
    assign sif.switching    = switching_reg;
    assign sif.done_pulse   = done_reg;
    assign sif.err_bad_slot = err_reg;

    uprj_bus_mux #(
        .NUM_SLOTS (NUM_SLOTS),
        .SEL_W     (SEL_W),
        .BUS_W     (BUS_W)
    ) u_bus_mux (
        .CLK     (CLK),
        .resetn  (resetn),
        .slot_in (sif.slot_in),
        .sel     (active_reg),
        .en      (bus_en_reg),
        .bus_out (sif.bus_out)
    );

endmodule

// File: tb/tb_uprj_slot_ctrl.sv
// Directed bench for uprj_slot_ctrl: a 4-slot instance for sequencing and a 3-slot instance
// for out-of-range requests, with hand-computed cycle-exact expectations.
module tb_uprj_slot_ctrl;

    localparam int BUS_W = 128;

    logic             CLK = 1'b0;
    logic             resetn;
    logic [BUS_W-1:0] slot_data [4];
    int               n_checks = 0;
    int               n_fails  = 0;

    uprj_slot_ctrl_if #(.NUM_SLOTS(4), .SEL_W(2), .BUS_W(BUS_W)) u_if ();
    uprj_slot_ctrl_if #(.NUM_SLOTS(3), .SEL_W(2), .BUS_W(BUS_W)) u3_if ();

    uprj_slot_ctrl #(
        .NUM_SLOTS(4), .SEL_W(2), .BUS_W(BUS_W), .QUIET_CYCLES(4), .RST_CYCLES(16)
    ) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .sif    (u_if.slave)
    );

    uprj_slot_ctrl #(
        .NUM_SLOTS(3), .SEL_W(2), .BUS_W(BUS_W), .QUIET_CYCLES(4), .RST_CYCLES(16)
    ) dut3 (
        .CLK    (CLK),
        .resetn (resetn),
        .sif    (u3_if.slave)
    );

    always #5 CLK = ~CLK;

    assign u_if.slot_in  = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
    assign u3_if.slot_in = {slot_data[2], slot_data[1], slot_data[0]};

    task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        resetn         = 1'b0;
        u_if.req_valid  = 1'b0;
        u_if.req_slot   = '0;
        u3_if.req_valid = 1'b0;
        u3_if.req_slot  = '0;
        slot_data[0] = {4{32'hA000_0000}};
        slot_data[1] = {4{32'hB111_1111}};
        slot_data[2] = {4{32'hC222_2222}};
        slot_data[3] = {4{32'hD333_3333}};

        // Reset values
        tick(3);
        check("rst_slot_rst", u_if.slot_rst, 4'b1111);
        check("rst_active", u_if.active_slot, 2'd0);
        check("rst_switching", u_if.switching, 1'b1);
        check("rst_ready", u_if.req_ready, 1'b0);
        check("rst_done", u_if.done_pulse, 1'b0);
        check("rst_err", u_if.err_bad_slot, 1'b0);
        check("rst_bus", u_if.bus_out, '0);

        // Post-reset slot-0 hold window
        resetn = 1'b1;
        $display("reset released at %0t", $time);
        tick(15);
        check("boot_hold_rst", u_if.slot_rst, 4'b1111);
        check("boot_hold_ready", u_if.req_ready, 1'b0);
        tick(1);
        check("boot_idle_rst", u_if.slot_rst, 4'b1110);
        check("boot_idle_ready", u_if.req_ready, 1'b1);
        check("boot_idle_done", u_if.done_pulse, 1'b1);
        check("boot3_idle_rst", u3_if.slot_rst, 3'b110);
        tick(1);
        check("boot_bus", u_if.bus_out, slot_data[0]);
        check("boot_done_clr", u_if.done_pulse, 1'b0);

        // Switch to slot 2
        $display("req slot 2 (from slot 0) at %0t", $time);
        u_if.req_valid = 1'b1;
        u_if.req_slot  = 2'd2;
        tick(1);
        u_if.req_valid = 1'b0;
        check("sw2_t1_ready", u_if.req_ready, 1'b0);
        check("sw2_t1_switching", u_if.switching, 1'b1);
        check("sw2_t1_rst", u_if.slot_rst, 4'b1111);
        check("sw2_t1_bus", u_if.bus_out, slot_data[0]);
        tick(1);
        check("sw2_t2_bus", u_if.bus_out, '0);
        tick(3);
        check("sw2_t5_active", u_if.active_slot, 2'd0);
        tick(1);
        check("sw2_t6_active", u_if.active_slot, 2'd2);
        tick(15);
        check("sw2_t21_ready", u_if.req_ready, 1'b0);
        check("sw2_t21_rst", u_if.slot_rst, 4'b1111);
        tick(1);
        check("sw2_t22_rst", u_if.slot_rst, 4'b1011);
        check("sw2_t22_ready", u_if.req_ready, 1'b1);
        check("sw2_t22_done", u_if.done_pulse, 1'b1);
        check("sw2_t22_switching", u_if.switching, 1'b0);
        tick(1);
        check("sw2_t23_bus", u_if.bus_out, slot_data[2]);

        // Out-of-range request on the 3-slot instance
        $display("req slot 3 on 3-slot instance at %0t", $time);
        u3_if.req_valid = 1'b1;
        u3_if.req_slot  = 2'd3;
        tick(1);
        u3_if.req_valid = 1'b0;
        check("bad_err", u3_if.err_bad_slot, 1'b1);
        check("bad_ready", u3_if.req_ready, 1'b1);
        check("bad_switching", u3_if.switching, 1'b0);
        check("bad_done", u3_if.done_pulse, 1'b0);
        check("bad_active", u3_if.active_slot, 2'd0);
        tick(1);
        check("bad_switching_t2", u3_if.switching, 1'b0);
        check("bad_done_t2", u3_if.done_pulse, 1'b0);
        $display("req slot 2 on 3-slot instance at %0t", $time);
        u3_if.req_valid = 1'b1;
        u3_if.req_slot  = 2'd2;
        tick(1);
        u3_if.req_valid = 1'b0;
        check("bad_next_switching", u3_if.switching, 1'b1);
        tick(21);
        check("bad_next_active", u3_if.active_slot, 2'd2);
        check("bad_next_rst", u3_if.slot_rst, 3'b011);
        check("bad_next_done", u3_if.done_pulse, 1'b1);
        check("bad_err_sticky", u3_if.err_bad_slot, 1'b1);

        // Switch to slot 1
        $display("req slot 1 (from slot 2) at %0t", $time);
        u_if.req_valid = 1'b1;
        u_if.req_slot  = 2'd1;
        tick(1);
        u_if.req_valid = 1'b0;
        tick(21);
        check("sw1_active", u_if.active_slot, 2'd1);
        check("sw1_rst", u_if.slot_rst, 4'b1101);
        check("sw1_done", u_if.done_pulse, 1'b1);

        // Soft reset of current slot 1, with a held request for slot 3 arriving mid-sequence
        $display("req slot 1 (soft reset of current) at %0t", $time);
        u_if.req_valid = 1'b1;
        u_if.req_slot  = 2'd1;
        tick(1);
        u_if.req_valid = 1'b0;
        check("soft_t1_rst", u_if.slot_rst, 4'b1111);
        check("soft_t1_switching", u_if.switching, 1'b1);
        tick(2);
        $display("req slot 3 held during sequence at %0t", $time);
        u_if.req_valid = 1'b1;
        u_if.req_slot  = 2'd3;
        tick(2);
        check("held_t5_ready", u_if.req_ready, 1'b0);
        check("held_t5_active", u_if.active_slot, 2'd1);
        tick(1);
        check("soft_t6_active", u_if.active_slot, 2'd1);
        tick(15);
        check("soft_t21_rst", u_if.slot_rst, 4'b1111);
        check("soft_t21_switching", u_if.switching, 1'b1);
        tick(1);
        check("soft_t22_done", u_if.done_pulse, 1'b1);
        check("soft_t22_ready", u_if.req_ready, 1'b1);
        check("soft_t22_rst", u_if.slot_rst, 4'b1101);
        check("soft_t22_active", u_if.active_slot, 2'd1);
        tick(1);
        u_if.req_valid = 1'b0;
        check("held_acc_ready", u_if.req_ready, 1'b0);
        check("held_acc_switching", u_if.switching, 1'b1);
        check("held_acc_done", u_if.done_pulse, 1'b0);
        tick(4);
        check("held_t5_active_old", u_if.active_slot, 2'd1);
        tick(1);
        check("held_t6_active", u_if.active_slot, 2'd3);
        tick(16);
        check("held_t22_rst", u_if.slot_rst, 4'b0111);
        check("held_t22_done", u_if.done_pulse, 1'b1);
        tick(1);
        check("held_t23_bus", u_if.bus_out, slot_data[3]);

        // One-cycle bus latency in IDLE
        slot_data[3] = {4{32'h5A5A_F00D}};
        $display("slot 3 data changed at %0t", $time);
        tick(1);
        check("idle_latency_bus", u_if.bus_out, {4{32'h5A5A_F00D}});

        // Reset asserted during HOLD
        $display("req slot 2 then reset during HOLD at %0t", $time);
        u_if.req_valid = 1'b1;
        u_if.req_slot  = 2'd2;
        tick(1);
        u_if.req_valid = 1'b0;
        tick(9);
        check("pre_abort_active", u_if.active_slot, 2'd2);
        resetn = 1'b0;
        #1;
        check("abort_rst", u_if.slot_rst, 4'b1111);
        check("abort_active", u_if.active_slot, 2'd0);
        check("abort_switching", u_if.switching, 1'b1);
        check("abort_ready", u_if.req_ready, 1'b0);
        check("abort_bus", u_if.bus_out, '0);
        check("abort_err3", u3_if.err_bad_slot, 1'b0);
        tick(2);
        resetn = 1'b1;
        $display("reset released at %0t", $time);
        tick(15);
        check("reboot_hold_rst", u_if.slot_rst, 4'b1111);
        tick(1);
        check("reboot_idle_rst", u_if.slot_rst, 4'b1110);
        check("reboot_idle_done", u_if.done_pulse, 1'b1);
        check("reboot_idle_active", u_if.active_slot, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
